// File: rtl/complex_multiplier_pipe_if.sv
// Streaming bus for the pipelined complex multiplier: operand input handshake
// plus result output handshake.
interface complex_multiplier_pipe_if #(
   parameter int unsigned A_W   = 16,
   parameter int unsigned B_W   = 18,
   parameter int unsigned OUT_W = 35
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    conj_b;
   logic signed [A_W-1:0]   real_part_a;
   logic signed [A_W-1:0]   imag_part_a;
   logic signed [B_W-1:0]   real_part_b;
   logic signed [B_W-1:0]   imag_part_b;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] real_output;
   logic signed [OUT_W-1:0] imag_output;
   logic                    sat_flag;

   modport master (
      output in_valid, conj_b, real_part_a, imag_part_a, real_part_b, imag_part_b, out_ready,
      input  in_ready, out_valid, real_output, imag_output, sat_flag
   );

   modport slave (
      input  in_valid, conj_b, real_part_a, imag_part_a, real_part_b, imag_part_b, out_ready,
      output in_ready, out_valid, real_output, imag_output, sat_flag
   );
endinterface

// File: rtl/complex_multiplier_pipe.sv
// Three-stage signed complex multiplier with optional conj(B), round-half-up
// scaling and output saturation; one global stall enable drives every stage.
module complex_multiplier_pipe #(
   parameter int unsigned A_W   = 16,
   parameter int unsigned B_W   = 18,
   parameter int unsigned OUT_W = 35,
   parameter int unsigned SHIFT = 0
) (
   input logic                      clk,
   input logic                      rst,
   complex_multiplier_pipe_if.slave bus
);
   localparam int unsigned PW = A_W + B_W;
   // One bit for the add/sub, one more so the rounding constant cannot wrap.
   localparam int unsigned RW = PW + 2;
   localparam int unsigned W  = (RW > OUT_W) ? RW : OUT_W;
   localparam int unsigned RndSh = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [RW-1:0] RndC = (SHIFT > 0) ? (RW'(1) << RndSh) : RW'(0);
   localparam logic signed [W-1:0] MaxV = {{(W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [W-1:0] MinV = ~MaxV;

   logic                    w_en;
   logic                    r_v1, r_v2, r_out_valid;
   logic                    r_conj1, r_conj2;
   logic signed [A_W-1:0]   r_ar1, r_ai1;
   logic signed [B_W-1:0]   r_br1, r_bi1;
   logic signed [PW-1:0]    r_p_rr, r_p_ii, r_p_ri, r_p_ir;
   logic signed [RW-1:0]    w_re_full, w_im_full, w_re_sh, w_im_sh;
   logic signed [W-1:0]     w_re_w, w_im_w;
   logic signed [OUT_W-1:0] w_re_sat, w_im_sat;
   logic                    w_re_clip, w_im_clip;
   logic signed [OUT_W-1:0] r_real, r_imag;
   logic                    r_sat;

   function automatic logic [OUT_W:0] sat_fn(input logic signed [W-1:0] v);
      if (v > MaxV) begin
         return {1'b1, MaxV[OUT_W-1:0]};
      end else if (v < MinV) begin
         return {1'b1, MinV[OUT_W-1:0]};
      end
      return {1'b0, v[OUT_W-1:0]};
   endfunction

   assign w_en         = rst & (~r_out_valid | bus.out_ready);
   assign bus.in_ready = w_en;
   assign bus.out_valid   = r_out_valid;
   assign bus.real_output = r_real;
   assign bus.imag_output = r_imag;
   assign bus.sat_flag    = r_sat;

   always_comb begin
      if (r_conj2) begin
         w_re_full = RW'(r_p_rr) + RW'(r_p_ii);
         w_im_full = RW'(r_p_ir) - RW'(r_p_ri);
      end else begin
         w_re_full = RW'(r_p_rr) - RW'(r_p_ii);
         w_im_full = RW'(r_p_ri) + RW'(r_p_ir);
      end
      w_re_sh = (w_re_full + RndC) >>> SHIFT;
      w_im_sh = (w_im_full + RndC) >>> SHIFT;
      w_re_w  = W'(w_re_sh);
      w_im_w  = W'(w_im_sh);
      {w_re_clip, w_re_sat} = sat_fn(w_re_w);
      {w_im_clip, w_im_sat} = sat_fn(w_im_w);
   end

   // Valid bits and visible outputs are reset; datapath stages carry stale data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_out_valid <= 1'b0;
         r_real      <= '0;
         r_imag      <= '0;
         r_sat       <= 1'b0;
      end else if (w_en) begin
         r_v1        <= bus.in_valid;
         r_v2        <= r_v1;
         r_out_valid <= r_v2;
         if (r_v2) begin
            r_real <= w_re_sat;
            r_imag <= w_im_sat;
            r_sat  <= w_re_clip | w_im_clip;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_en) begin
         r_conj1 <= bus.conj_b;
         r_ar1   <= bus.real_part_a;
         r_ai1   <= bus.imag_part_a;
         r_br1   <= bus.real_part_b;
         r_bi1   <= bus.imag_part_b;
         r_conj2 <= r_conj1;
         r_p_rr  <= PW'(r_ar1) * PW'(r_br1);
         r_p_ii  <= PW'(r_ai1) * PW'(r_bi1);
         r_p_ri  <= PW'(r_ar1) * PW'(r_bi1);
         r_p_ir  <= PW'(r_ai1) * PW'(r_br1);
      end
   end
endmodule

// File: tb/tb_complex_multiplier_pipe.sv
// Self-checking bench: default, saturating (OUT_W=20) and scaled (SHIFT=4)
// instances checked against a plain-arithmetic complex multiply model.
module tb_complex_multiplier_pipe;
   typedef struct {
      longint re;
      longint im;
      longint sat;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_out = 0;
   res_t q[$];
   bit   acc;
   int   budget;
   res_t e1, e2;
   logic signed [15:0] ar, ai;
   logic signed [17:0] br, bi;
   bit   cj;
   int   b4[4];
   int   x4[4];

   always #5 clk = ~clk;

   complex_multiplier_pipe_if #(.A_W(16), .B_W(18), .OUT_W(35)) b0 ();
   complex_multiplier_pipe_if #(.A_W(16), .B_W(18), .OUT_W(20)) b1 ();
   complex_multiplier_pipe_if #(.A_W(16), .B_W(18), .OUT_W(31)) b2 ();

   complex_multiplier_pipe #(.A_W(16), .B_W(18), .OUT_W(35), .SHIFT(0)) u0 (
      .clk(clk), .rst(rst), .bus(b0));
   complex_multiplier_pipe #(.A_W(16), .B_W(18), .OUT_W(20), .SHIFT(0)) u1 (
      .clk(clk), .rst(rst), .bus(b1));
   complex_multiplier_pipe #(.A_W(16), .B_W(18), .OUT_W(31), .SHIFT(4)) u2 (
      .clk(clk), .rst(rst), .bus(b2));

   function automatic res_t model(input longint a_r, input longint a_i, input longint b_r,
                                  input longint b_i, input bit c, input int ow, input int sh);
      res_t   r;
      longint re, im, mx, mn;
      re = c ? a_r * b_r + a_i * b_i : a_r * b_r - a_i * b_i;
      im = c ? a_i * b_r - a_r * b_i : a_r * b_i + a_i * b_r;
      if (sh > 0) begin
         re = (re + (longint'(1) << (sh - 1))) >>> sh;
         im = (im + (longint'(1) << (sh - 1))) >>> sh;
      end
      mx = (longint'(1) << (ow - 1)) - 1;
      mn = -mx - 1;
      r.sat = 0;
      if (re > mx) begin re = mx; r.sat = 1; end
      else if (re < mn) begin re = mn; r.sat = 1; end
      if (im > mx) begin im = mx; r.sat = 1; end
      else if (im < mn) begin im = mn; r.sat = 1; end
      r.re = re;
      r.im = im;
      return r;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic signed [15:0] a_r, input logic signed [15:0] a_i,
                         input logic signed [17:0] b_r, input logic signed [17:0] b_i,
                         input bit c);
      b0.real_part_a = a_r;
      b0.imag_part_a = a_i;
      b0.real_part_b = b_r;
      b0.imag_part_b = b_i;
      b0.conj_b      = c;
   endtask

   task automatic drive0_rand();
      drive0(16'($urandom), 16'($urandom), 18'($urandom), 18'($urandom), 1'($urandom));
   endtask

   // One cycle on u0 with scoreboarding of both handshakes.
   task automatic tick(output bit a);
      res_t e;
      @(negedge clk);
      a = b0.in_valid && b0.in_ready;
      if (b0.out_valid && b0.out_ready) begin
         n_out++;
         chk("sb_expected_pending", longint'(q.size() > 0), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_re", b0.real_output, e.re);
            chk("sb_im", b0.imag_output, e.im);
            chk("sb_sat", b0.sat_flag, e.sat);
         end
      end
      if (a) begin
         q.push_back(model(b0.real_part_a, b0.imag_part_a, b0.real_part_b, b0.imag_part_b,
                           b0.conj_b, 35, 0));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      b0.in_valid = 1'b0; b0.out_ready = 1'b1; drive0(0, 0, 0, 0, 0);
      b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.conj_b = 1'b0;
      b1.real_part_a = '0; b1.imag_part_a = '0; b1.real_part_b = '0; b1.imag_part_b = '0;
      b2.in_valid = 1'b0; b2.out_ready = 1'b1; b2.conj_b = 1'b0;
      b2.real_part_a = '0; b2.imag_part_a = '0; b2.real_part_b = '0; b2.imag_part_b = '0;

      // Reset state
      step(); step();
      chk("rst_in_ready", b0.in_ready, 0);
      chk("rst_out_valid", b0.out_valid, 0);
      chk("rst_real", b0.real_output, 0);
      chk("rst_imag", b0.imag_output, 0);
      chk("rst_sat", b0.sat_flag, 0);
      rst = 1'b1;
      #1;
      chk("in_ready_after_rst", b0.in_ready, 1);

      // Test 1: exact 3-edge latency, plain and conjugate
      for (int c = 0; c < 2; c++) begin
         drive0(3, 4, 5, 6, c[0]);
         b0.in_valid = 1'b1;
         step();
         b0.in_valid = 1'b0;
         chk("lat_e1_valid", b0.out_valid, 0);
         step();
         chk("lat_e2_valid", b0.out_valid, 0);
         step();
         chk("lat_e3_valid", b0.out_valid, 1);
         chk("t1_re", b0.real_output, c == 0 ? -9 : 39);
         chk("t1_im", b0.imag_output, c == 0 ? 38 : 2);
         chk("t1_sat", b0.sat_flag, 0);
         step();
         chk("t1_valid_clears", b0.out_valid, 0);
      end

      // Test 2: 10 random back-to-back samples at full throughput
      n_out = 0;
      for (int i = 0; i < 10; i++) begin
         drive0_rand();
         b0.in_valid = 1'b1;
         tick(acc);
         chk("t2_accept", acc, 1);
      end
      b0.in_valid = 1'b0;
      chk("t2_outs_during_stream", n_out, 7);
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         tick(acc);
         budget++;
      end
      chk("t2_drain_cycles", budget, 3);
      chk("t2_total_outs", n_out, 10);

      // Test 3: saturation at OUT_W=20
      b1.real_part_a = 16'sd32767; b1.imag_part_a = '0;
      b1.real_part_b = 18'sd131071; b1.imag_part_b = '0;
      b1.conj_b = 1'b0; b1.in_valid = 1'b1;
      step();
      b1.real_part_a = 16'h8000;
      step();
      b1.in_valid = 1'b0;
      step();
      chk("t3_pos_valid", b1.out_valid, 1);
      chk("t3_pos_re", b1.real_output, 524287);
      chk("t3_pos_im", b1.imag_output, 0);
      chk("t3_pos_sat", b1.sat_flag, 1);
      step();
      chk("t3_neg_valid", b1.out_valid, 1);
      chk("t3_neg_re", b1.real_output, -524288);
      chk("t3_neg_sat", b1.sat_flag, 1);
      step();

      // Test 4: round half up with SHIFT=4
      b4 = '{8, 7, -8, -9};
      x4 = '{1, 0, 0, -1};
      for (int i = 0; i < 4; i++) begin
         b2.real_part_a = 16'sd1; b2.imag_part_a = '0;
         b2.real_part_b = 18'(b4[i]); b2.imag_part_b = '0;
         b2.conj_b = 1'b0; b2.in_valid = 1'b1;
         step();
         b2.in_valid = 1'b0;
         step(); step();
         chk("t4_valid", b2.out_valid, 1);
         chk("t4_re", b2.real_output, x4[i]);
         chk("t4_im", b2.imag_output, 0);
         chk("t4_sat", b2.sat_flag, 0);
         step();
      end

      // Random samples through the saturating and scaled instances
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            ar = 16'($urandom_range(0, 255)) - 16'sd128;
            ai = 16'($urandom_range(0, 255)) - 16'sd128;
            br = 18'($urandom_range(0, 1023)) - 18'sd512;
            bi = 18'($urandom_range(0, 1023)) - 18'sd512;
         end else begin
            ar = 16'($urandom); ai = 16'($urandom);
            br = 18'($urandom); bi = 18'($urandom);
         end
         cj = 1'($urandom);
         b1.real_part_a = ar; b1.imag_part_a = ai; b1.real_part_b = br; b1.imag_part_b = bi;
         b2.real_part_a = ar; b2.imag_part_a = ai; b2.real_part_b = br; b2.imag_part_b = bi;
         b1.conj_b = cj; b2.conj_b = cj;
         b1.in_valid = 1'b1; b2.in_valid = 1'b1;
         e1 = model(ar, ai, br, bi, cj, 20, 0);
         e2 = model(ar, ai, br, bi, cj, 31, 4);
         step();
         b1.in_valid = 1'b0; b2.in_valid = 1'b0;
         step(); step();
         chk("r1_valid", b1.out_valid, 1);
         chk("r1_re", b1.real_output, e1.re);
         chk("r1_im", b1.imag_output, e1.im);
         chk("r1_sat", b1.sat_flag, e1.sat);
         chk("r2_valid", b2.out_valid, 1);
         chk("r2_re", b2.real_output, e2.re);
         chk("r2_im", b2.imag_output, e2.im);
         chk("r2_sat", b2.sat_flag, e2.sat);
         step();
      end

      // Test 5: backpressure fills the pipe, outputs hold, then release
      n_out = 0;
      b0.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive0_rand();
         b0.in_valid = 1'b1;
         acc = 1'b0;
         budget = 0;
         while (!acc && budget < 40) begin
            if (i == 3 && (budget == 1 || budget == 4)) begin
               chk("t5_in_ready_full", b0.in_ready, 0);
               chk("t5_out_valid_held", b0.out_valid, 1);
               chk("t5_re_held", b0.real_output, q[0].re);
               chk("t5_im_held", b0.imag_output, q[0].im);
               if (budget == 4) b0.out_ready = 1'b1;
            end
            tick(acc);
            budget++;
         end
         chk("t5_accepted", acc, 1);
      end
      b0.in_valid = 1'b0;
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         tick(acc);
         budget++;
      end
      chk("t5_queue_drained", q.size(), 0);
      chk("t5_total_outs", n_out, 6);

      // Test 6: reset with two samples in flight
      for (int i = 0; i < 2; i++) begin
         drive0_rand();
         b0.in_valid = 1'b1;
         tick(acc);
         chk("t6_accept", acc, 1);
      end
      b0.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("t6_in_ready_in_rst", b0.in_ready, 0);
      step();
      chk("t6_rst_valid", b0.out_valid, 0);
      chk("t6_rst_re", b0.real_output, 0);
      chk("t6_rst_im", b0.imag_output, 0);
      chk("t6_rst_sat", b0.sat_flag, 0);
      rst = 1'b1;
      q.delete();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_stale", b0.out_valid, 0);
      end
      drive0(3, 4, 5, 6, 1'b0);
      b0.in_valid = 1'b1;
      step();
      b0.in_valid = 1'b0;
      step();
      chk("t6_e2_valid", b0.out_valid, 0);
      step();
      chk("t6_e3_valid", b0.out_valid, 1);
      chk("t6_re", b0.real_output, -9);
      chk("t6_im", b0.imag_output, 38);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/complex_multiplier_pipe.md
Name: complex_multiplier_pipe

Overview:
- Parametrised, fully pipelined signed complex multiplier.
- Successor to the fixed 16x18 complex multiplier, adding:
  - configurable operand and output widths;
  - a per-sample conjugate mode;
  - round-half-up output scaling with saturation;
  - valid/ready handshakes on input and output, so it drops into streaming FFT, mixer and correlator datapaths.

Parameters:
- A_W, 16, signed width of operand A real/imag.
- B_W, 18, signed width of operand B real/imag.
- OUT_W, 35, signed width of each output component.
- SHIFT, 0, arithmetic right shift applied to the full-precision result before saturation (0..A_W+B_W).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- conj_b  in  1  when 1, multiply by conj(B) for this sample.
- real_part_a  in  A_W  signed Re(A).
- imag_part_a  in  A_W  signed Im(A).
- real_part_b  in  B_W  signed Re(B).
- imag_part_b  in  B_W  signed Im(B).
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- real_output  out  OUT_W  signed Re(result).
- imag_output  out  OUT_W  signed Im(result).
- sat_flag  out  1  either component saturated for this output sample.

Behaviour:
- Reset (rst=0 at a rising edge):
  - all stage valids, out_valid, real_output, imag_output and sat_flag go to 0 on that edge;
  - in_ready reads 0 while rst=0.
  - Reset mid-stream discards every in-flight sample and produces no partial outputs.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Three-stage pipeline with a global advance enable en = rst & (~out_valid | out_ready). in_ready = en.
  - S1: register operands and conj_b, plus a valid bit (valid = in_valid & in_ready).
  - S2: four signed products ar*br, ai*bi, ar*bi, ai*br, each A_W+B_W bits.
  - S3: sum, round, saturate; register outputs, out_valid and sat_flag.
- When en=0, every stage holds. Outputs stay stable while out_valid=1 and out_ready=0.
- Latency: exactly 3 clk edges from input transfer to out_valid, given no stall. Throughput is 1 sample/cycle with out_ready held high.
- Bubbles (invalid stages) advance like data. Sample order is always preserved; no sample is dropped or duplicated.
- Arithmetic, full precision P = A_W+B_W+1 bits, signed:
  - conj_b=0: re = ar*br - ai*bi, im = ar*bi + ai*br.
  - conj_b=1: re = ar*br + ai*bi, im = ai*br - ar*bi.
- Scaling, when SHIFT>0: add 2^(SHIFT-1), then arithmetic shift right by SHIFT. This is round half toward +infinity. When SHIFT=0, pass through unchanged.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat_flag=1 if either component clamped.
  - If OUT_W >= P-SHIFT, clamping never occurs and the result is sign-extended.
  - With the defaults (P=35), sat_flag is always 0.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Invalid stages may carry stale data. real_output and imag_output hold their last value when out_valid=0 (zero after reset).

Test Plan:
1. Defaults, conj_b=0, A=(3,4), B=(5,6), out_ready=1 -> three edges later out_valid=1, real_output=-9, imag_output=38, sat_flag=0.
2. Same operands with conj_b=1 -> real_output=39, imag_output=2. Then 10 random full-range back-to-back samples -> one output per cycle, matching the golden model in order.
3. Instance OUT_W=20, SHIFT=0, A=(32767,0), B=(131071,0) -> real_output=524287, sat_flag=1. A=(-32768,0), B=(131071,0) -> real_output=-524288, sat_flag=1.
4. Instance SHIFT=4, OUT_W=31, B imag=0, A=(1,0):
   - B=(8,0) -> real_output=1.
   - B=(7,0) -> real_output=0.
   - B=(-8,0) -> real_output=0.
   - B=(-9,0) -> real_output=-1.
5. Stream 6 samples while holding out_ready=0 -> first result appears and holds stable; in_ready=0 once out_valid=1, so the pipeline is full with 3 samples. Release out_ready -> all 6 results emerge in order, with no loss or duplicates.
6. Drive rst=0 for one edge with 2 samples in flight -> out_valid=0 and outputs 0 after that edge; no stale outputs once rst=1. A new sample then returns after exactly 3 edges.
